instr_encoder_loader: RTL and testbench

Inverse of the decode-stage control unit: converts a one-hot operation select plus register/immediate fields into 32-bit instruction words and streams them into instruction memory at consecutive addresses. The block sits on the program-load path ahead of fetch. It is driven by a test harness or boot loader through a valid/ready handshake. It emits registered memory writes with back-pressure.

---
 rtl/instr_encoder_loader.sv | 92 +++++++++
 tb/tb_instr_encoder_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes one-hot op/register fields into instruction words and streams them into memory
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       op_sel,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic              in_imm_en,
  input  logic [18:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_busy,
  output logic              busy,
  output logic              done,
  output logic              err_onehot,
  output logic              err_wrap,
  output logic [ADDR_W:0]   wr_count
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] remaining;
  logic [3:0] opcode;
  logic [31:0] word;
  logic onehot, xfer, good, wr_done, start_ok;
  assign wr_done  = mem_we && !mem_busy;
  assign in_ready = (state == LOAD) && (remaining != '0) && !(mem_we && mem_busy);
  assign xfer     = in_valid && in_ready;
  assign onehot   = (op_sel != '0) && ((op_sel & (op_sel - 16'd1)) == '0);
  assign good     = xfer && onehot;
  assign start_ok = (state == IDLE) && start;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  always_comb begin
    opcode = '0;
    for (int i = 0; i < 16; i++)
      if (op_sel[i]) opcode = 4'(i);
  end
  assign word = {opcode, in_imm_en, in_rd, in_rs1, in_imm_en ? in_imm : {in_rs2, 15'b0}};
  always_comb begin
    state_n = state == IDLE  ? (start ? (count == '0 ? DONE : LOAD) : IDLE) :
              state == LOAD  ? (good && remaining == (ADDR_W+1)'(1) ? FLUSH : LOAD) :
              state == FLUSH ? (wr_done ? DONE : FLUSH) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      remaining  <= '0;
      wr_count   <= '0;
      err_onehot <= 1'b0;
      err_wrap   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (start_ok) begin
        addr       <= base_addr;
        remaining  <= count;
        wr_count   <= '0;
        err_onehot <= 1'b0;
        err_wrap   <= 1'b0;
      end else begin
        if (wr_done) wr_count <= wr_count + (ADDR_W+1)'(1);
        if (xfer && !onehot) err_onehot <= 1'b1;
        if (good) begin
          remaining <= remaining - (ADDR_W+1)'(1);
          addr      <= addr + ADDR_W'(1);
          if (&addr) err_wrap <= 1'b1;
        end
      end
      // a completing write and a new transfer in the same cycle reload back-to-back
      if (good) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr;
        mem_wdata <= word;
      end else if (wr_done) mem_we <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: vector table, corner sequences and randomized sessions against a queue-based model
module tb_instr_encoder_loader;
  typedef struct {
    logic [15:0] op;
    logic [3:0]  rd, rs1, rs2;
    logic        ie;
    logic [18:0] imm;
    logic [31:0] exp;
  } vec_t;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, in_imm_en = 0, mem_busy = 0;
  logic [7:0] base_addr = 0;
  logic [8:0] count = 0;
  logic [15:0] op_sel = 0;
  logic [3:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [18:0] in_imm = 0;
  logic in_ready, mem_we, busy, done, err_onehot, err_wrap;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0] wr_count;
  int checks = 0, failures = 0, done_seen = 0, force_stall = 0;
  bit busy_rand = 0;
  logic [39:0] exp_q[$];
  logic [7:0] m_addr;
  int m_rem;
  bit m_err1, m_errw;
  vec_t tv[6];

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm_en(in_imm_en), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
    .busy(busy), .done(done), .err_onehot(err_onehot), .err_wrap(err_wrap),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (force_stall > 0) begin
      mem_busy = 1;
      force_stall--;
    end else mem_busy = busy_rand && ($urandom_range(0, 2) == 0);
  end

  function automatic logic [31:0] enc(vec_t v);
    int oc = 0;
    longint w;
    for (int i = 0; i < 16; i++) if (v.op == 16'(1 << i)) oc = i;
    w = longint'(oc) * 2**28 + longint'(v.ie) * 2**27 + longint'(v.rd) * 2**23 +
        longint'(v.rs1) * 2**19 + (v.ie ? longint'(v.imm) : longint'(v.rs2) * 2**15);
    return 32'(w);
  endfunction

  task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (mem_we && !mem_busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
      end else chk("write", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
    if (done) begin
      done_seen++;
      chk("done_vs_mem_we", 40'(mem_we), 40'd0);
    end
  end

  task automatic begin_session(logic [7:0] b, logic [8:0] c);
    start = 1; base_addr = b; count = c;
    m_addr = b; m_rem = int'(c); m_err1 = 0; m_errw = 0;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(vec_t v);
    bit ok = 0;
    in_valid = 1; op_sel = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_imm_en = v.ie; in_imm = v.imm;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (in_ready) begin
        ok = 1;
        if ($countones(v.op) == 1) begin
          exp_q.push_back({m_addr, enc(v)});
          if (m_addr == 8'hFF) m_errw = 1;
          m_addr++;
          m_rem--;
        end else m_err1 = 1;
      end
      @(negedge clk);
    end
    in_valid = 0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: done stayed 0, required 1");
    end else chk("in_ready_in_done", 40'(in_ready), 40'd0);
  endtask

  task automatic finish_session(int n);
    @(negedge clk);
    chk("busy_after_done", 40'(busy), 40'd0);
    chk("wr_count", 40'(wr_count), 40'(n));
    chk("err_onehot", 40'(err_onehot), 40'(m_err1));
    chk("err_wrap", 40'(err_wrap), 40'(m_errw));
    chk("queue_drained", 40'(exp_q.size()), 40'd0);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.op = (16'd1 << $urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0)
      v.op = $urandom_range(0, 1) ? 16'h0 : (v.op | (16'd1 << ((int'($clog2(v.op)) + $urandom_range(1, 15)) % 16)));
    v.rd = 4'($urandom); v.rs1 = 4'($urandom); v.rs2 = 4'($urandom);
    v.ie = 1'($urandom); v.imm = 19'($urandom);
    v.exp = 0;
    return v;
  endfunction

  initial begin
    int d0;
    vec_t v;
    tv[0] = '{16'h0001, 4'd1, 4'd2, 4'd3, 1'b0, 19'h0, 32'h00918000};
    tv[1] = '{16'h2000, 4'd0, 4'd5, 4'd0, 1'b1, 19'h7FFFF, 32'hD82FFFFF};
    tv[2] = '{16'h0002, 4'd15, 4'd15, 4'd15, 1'b0, 19'h0, 32'h17FF8000};
    tv[3] = '{16'h8000, 4'd3, 4'd0, 4'd0, 1'b1, 19'h12345, 32'hF9812345};
    tv[4] = '{16'h0008, 4'd2, 4'd7, 4'd9, 1'b1, 19'h00010, 32'h39380010};
    tv[5] = '{16'h0040, 4'd4, 4'd1, 4'd0, 1'b0, 19'h0, 32'h62080000};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 40'(in_ready), 40'd0);
    chk("rst_mem_we", 40'(mem_we), 40'd0);
    chk("rst_mem_addr_data", {mem_addr, mem_wdata}, 40'd0);
    chk("rst_busy_done", {38'd0, busy, done}, 40'd0);
    chk("rst_errs", {38'd0, err_onehot, err_wrap}, 40'd0);
    chk("rst_wr_count", 40'(wr_count), 40'd0);
    reset = 0;
    @(negedge clk);
    chk("idle_busy", 40'(busy), 40'd0);

    for (int i = 0; i < 6; i++) begin
      begin_session(8'(16 + i), 9'd1);
      chk("start_busy", 40'(busy), 40'd1);
      send(tv[i]);
      chk("vec_we", 40'(mem_we), 40'd1);
      chk("vec_word", {mem_addr, mem_wdata}, {8'(16 + i), tv[i].exp});
      @(negedge clk);
      chk("vec_done_timing", 40'(done), 40'd1);
      wait_done();
      finish_session(1);
    end

    @(negedge clk);
    start = 1; base_addr = 8'h30; count = 0;
    @(negedge clk);
    start = 0;
    chk("cnt0_done", {37'd0, done, busy, in_ready}, {37'd0, 3'b110});
    chk("cnt0_we", 40'(mem_we), 40'd0);
    @(negedge clk);
    chk("cnt0_after", {38'd0, done, busy}, 40'd0);
    chk("cnt0_wr_count", 40'(wr_count), 40'd0);

    begin_session(8'h60, 9'd4);
    v = tv[0];
    send(v);
    force_stall = 3;
    v.rd = 4'd7;
    send(v);
    chk("stall_in_ready", 40'(in_ready), 40'd0);
    chk("stall_pending", {31'd0, mem_we, mem_addr}, {31'd1, 8'h61});
    v.rd = 4'd8;
    send(v);
    v.rd = 4'd9;
    send(v);
    wait_done();
    finish_session(4);

    d0 = done_seen;
    begin_session(8'h50, 9'd1);
    v = tv[5];
    v.op = 16'h0003;
    send(v);
    v.op = 16'h0000;
    send(v);
    send(tv[5]);
    wait_done();
    finish_session(1);
    chk("invalid_err_onehot", 40'(err_onehot), 40'd1);
    chk("invalid_done_once", 40'(done_seen - d0), 40'd1);

    begin_session(8'hFF, 9'd2);
    send(tv[1]);
    send(tv[2]);
    wait_done();
    finish_session(2);
    chk("wrap_err", 40'(err_wrap), 40'd1);

    begin_session(8'h40, 9'd2);
    send(tv[3]);
    start = 1; base_addr = 8'h80; count = 9'd1;
    @(negedge clk);
    start = 0;
    send(tv[4]);
    wait_done();
    finish_session(2);

    begin_session(8'h20, 9'd1);
    force_stall = 20;
    send(tv[0]);
    chk("flush_pending", {38'd0, mem_we, busy}, {38'd0, 2'b11});
    reset = 1;
    #1;
    chk("rst_flush", {37'd0, mem_we, busy, in_ready}, 40'd0);
    exp_q.delete();
    force_stall = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("post_rst_we", {38'd0, mem_we, busy}, 40'd0);

    busy_rand = 1;
    for (int s = 0; s < 25; s++) begin
      int n;
      n = $urandom_range(1, 6);
      d0 = done_seen;
      begin_session((s % 5 == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom), 9'(n));
      while (m_rem > 0) begin
        send(rand_vec());
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      wait_done();
      finish_session(n);
      chk("rand_done_once", 40'(done_seen - d0), 40'd1);
    end
    busy_rand = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
